// File: rtl/ripple_count_sampler.sv
// Brings a free-running asynchronous ripple-counter value into the clk domain, filters ripple
// transients, extends it with a wrap count and presents it on a valid/ready port.
// Optional build macro: RCS_SKIP_CHK_EN (flags accepted deltas larger than one).
module ripple_count_sampler #(
  parameter int IN_W       = 4,
  parameter int EXT_W      = 12,
  parameter int STABLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       cnt_in,
  input  logic                  smp_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXT_W+IN_W-1:0] out_count,
  output logic                  wrap_pulse,
  output logic                  ovf,
  output logic                  err_skip
);
  localparam int OUT_W  = EXT_W + IN_W;
  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE = 2'd0, BASE = 2'd1, TRACK = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   s1_q, s2_q;
  logic [IN_W-1:0]   cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              accept;
  logic [IN_W-1:0]   prev_q, prev_d;
  logic [EXT_W-1:0]  wrap_cnt_q, wrap_cnt_d;
  logic [EXT_W:0]    wrap_nxt;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              ovf_q, ovf_d;
  logic              emit;
  logic [OUT_W-1:0]  ext;
  logic [OUT_W-1:0]  out_count_q, out_count_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  park_q, park_d;
  logic              park_vld_q, park_vld_d;
  logic              xfer;

  function automatic logic [STAB_W-1:0] stab_sat_inc(input logic [STAB_W-1:0] s);
    return (s >= STAB_MAX) ? STAB_MAX : s + 1'b1;
  endfunction

  // MSB of the result is the carry out of an all-ones wrap counter.
  function automatic logic [EXT_W:0] wrap_inc(input logic [EXT_W-1:0] w);
    return {&w, w + 1'b1};
  endfunction

  assign wrap_nxt = wrap_inc(wrap_cnt_q);

  // Stage 1: stability filter on the synchronised value
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    accept = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = STAB_W'(1);
      accept = (STABLE_CYC == 1);
    end else begin
      stab_d = stab_sat_inc(stab_q);
      accept = (stab_q != STAB_MAX) && (stab_d == STAB_MAX);
    end
  end

  // Stage 2: baseline/tracking FSM and wrap extension
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    ovf_d        = ovf_q;
    emit         = 1'b0;
    case (state_q)
      IDLE: begin
        if (smp_en) state_d = BASE;
      end
      BASE: begin
        if (!smp_en) begin
          state_d = IDLE;
        end else if (accept) begin
          prev_d  = cand_d;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!smp_en) begin
          state_d = IDLE;
        end else if (accept && (cand_d != prev_q)) begin
          emit   = 1'b1;
          prev_d = cand_d;
          if (cand_d < prev_q) begin
            wrap_cnt_d   = wrap_nxt[EXT_W-1:0];
            wrap_pulse_d = 1'b1;
            if (wrap_nxt[EXT_W]) ovf_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ext  = {wrap_cnt_d, cand_d};
  assign xfer = out_valid_q && out_ready;

  // Stage 3: output register with a single latest-wins park slot
  always_comb begin
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    park_d      = park_q;
    park_vld_d  = park_vld_q;
    if (emit) begin
      if (!out_valid_q || out_ready) begin
        out_count_d = ext;
        out_valid_d = 1'b1;
        park_vld_d  = 1'b0;
      end else begin
        park_d     = ext;
        park_vld_d = 1'b1;
      end
    end else if (xfer) begin
      if (park_vld_q && (park_q != out_count_q)) begin
        out_count_d = park_q;
      end else begin
        out_valid_d = 1'b0;
      end
      park_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      cand_q       <= '0;
      stab_q       <= '0;
      state_q      <= IDLE;
      prev_q       <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
      ovf_q        <= 1'b0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      park_q       <= '0;
      park_vld_q   <= 1'b0;
    end else begin
      s1_q         <= cnt_in;
      s2_q         <= s1_q;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      state_q      <= state_d;
      prev_q       <= prev_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
      ovf_q        <= ovf_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      park_q       <= park_d;
      park_vld_q   <= park_vld_d;
    end
  end

`ifdef RCS_SKIP_CHK_EN
  logic [IN_W-1:0] delta;
  logic            err_skip_q, err_skip_d;

  // Modular distance, so a wrap from all-ones to zero counts as a step of one.
  assign delta = cand_d - prev_q;

  always_comb begin
    err_skip_d = err_skip_q;
    if (emit && (delta > IN_W'(1))) err_skip_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_skip_q <= 1'b0;
    else     err_skip_q <= err_skip_d;
  end

  assign err_skip = err_skip_q;
`else
  assign err_skip = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_count  = out_count_q;
  assign wrap_pulse = wrap_pulse_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Self-checking bench for ripple_count_sampler: directed scenarios plus randomized stimulus
// compared cycle by cycle against a behavioural model.
module tb_ripple_count_sampler;
  localparam int STABLE_CYC = 2;
`ifdef RCS_SKIP_CHK_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp_en = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  cnt_in = 4'd9;
  logic        out_valid, wrap_pulse, ovf, err_skip;
  logic [15:0] out_count;
  logic        w1_valid, w1_pulse, w1_ovf, w1_skip;
  logic [4:0]  w1_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_count_sampler #(.IN_W(4), .EXT_W(12), .STABLE_CYC(STABLE_CYC)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .smp_en(smp_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .wrap_pulse(wrap_pulse), .ovf(ovf), .err_skip(err_skip)
  );

  ripple_count_sampler #(.IN_W(4), .EXT_W(1), .STABLE_CYC(STABLE_CYC)) dut_w1 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .smp_en(smp_en),
    .out_valid(w1_valid), .out_ready(out_ready), .out_count(w1_count),
    .wrap_pulse(w1_pulse), .ovf(w1_ovf), .err_skip(w1_skip)
  );

  // Behavioural reference: the filter sees the input sampled two edges earlier, and a value is
  // accepted when the run of identical filter inputs since reset reaches exactly STABLE_CYC.
  int samp[$];
  int hist[$];
  int mode, prev, wrap12, wrap1, m_count, m_park;
  bit m_valid, m_park_vld, m_pulse, m_ovf12, m_ovf1, m_skip;

  always @(posedge clk) begin : model_b
    int fin, run, v, ext;
    bit acc, emit;
    if (rst) begin
      samp.delete(); samp.push_back(0); samp.push_back(0);
      hist.delete();
      mode = 0; prev = 0; wrap12 = 0; wrap1 = 0; m_count = 0; m_park = 0;
      m_valid = 0; m_park_vld = 0; m_pulse = 0; m_ovf12 = 0; m_ovf1 = 0; m_skip = 0;
    end else begin
      fin = samp[samp.size()-2];
      hist.push_back(fin);
      if (hist.size() > 8) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size()-1; i >= 0; i--) begin
        if (hist[i] != fin) break;
        run++;
      end
      acc = (run == STABLE_CYC);
      v = fin; emit = 0; m_pulse = 0;
      if (!smp_en) mode = 0;
      else if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (acc) begin prev = v; mode = 2; end
      end else if (acc && v != prev) begin
        if (v < prev) begin
          m_pulse = 1;
          wrap12 = (wrap12 + 1) % 4096;
          wrap1 = (wrap1 + 1) % 2;
          if (wrap12 == 0) m_ovf12 = 1;
          if (wrap1 == 0) m_ovf1 = 1;
        end
        if (SKIP_EN && ((v - prev + 16) % 16) > 1) m_skip = 1;
        prev = v; emit = 1;
      end
      ext = wrap12 * 16 + v;
      if (emit) begin
        if (!m_valid || out_ready) begin m_count = ext; m_valid = 1; m_park_vld = 0; end
        else begin m_park = ext; m_park_vld = 1; end
      end else if (m_valid && out_ready) begin
        if (m_park_vld && m_park != m_count) m_count = m_park;
        else m_valid = 0;
        m_park_vld = 0;
      end
      samp.push_back(int'(cnt_in));
      if (samp.size() > 4) void'(samp.pop_front());
    end
  end

  task automatic test_reset();
    rst = 1'b1; smp_en = 1'b0; out_ready = 1'b0; cnt_in = 4'd9;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    checks++; if (out_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", out_count); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b want 0", wrap_pulse); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    checks++; if (err_skip !== 1'b0) begin errors++; $display("FAIL reset_skip: got %0b want 0", err_skip); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_baseline();
    int bad;
    bad = 0;
    smp_en = 1'b1; out_ready = 1'b1; cnt_in = 4'd5;
    repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL baseline_no_emit: got %0d valid cycles want 0", bad); end
    cnt_in = 4'd6;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_count !== 16'h0006) begin
      errors++; $display("FAIL first_emit: got valid=%0b count=%h want 1/0006", out_valid, out_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int seen8, unstable;
    seen8 = 0; unstable = 0;
    out_ready = 1'b0; cnt_in = 4'd7;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_count !== 16'h0007) begin
      errors++; $display("FAIL bp_first: got valid=%0b count=%h want 1/0007", out_valid, out_count); end
    cnt_in = 4'd8;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_count !== 16'h0007) unstable++;
    end
    cnt_in = 4'd9;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_count !== 16'h0007) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changed cycles want 0", unstable); end
    out_ready = 1'b1;
    @(negedge clk);
    if (out_valid === 1'b1 && out_count === 16'h0008) seen8++;
    checks++; if (out_valid !== 1'b1 || out_count !== 16'h0009) begin
      errors++; $display("FAIL bp_latest: got valid=%0b count=%h want 1/0009", out_valid, out_count); end
    @(negedge clk);
    if (out_valid === 1'b1 && out_count === 16'h0008) seen8++;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid=%0b want 0", out_valid); end
    checks++; if (seen8 != 0) begin errors++; $display("FAIL bp_dropped: got %0d presentations of 0008 want 0", seen8); end
  endtask

  task automatic test_wrap();
    int npulse;
    npulse = 0;
    out_ready = 1'b1; cnt_in = 4'd15;
    repeat (6) @(negedge clk);
    cnt_in = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (wrap_pulse === 1'b1) npulse++;
      if (i == 4) begin
        checks++; if (out_valid !== 1'b1 || out_count !== 16'h0010 || wrap_pulse !== 1'b1) begin
          errors++; $display("FAIL wrap_emit: got valid=%0b count=%h pulse=%0b want 1/0010/1", out_valid, out_count, wrap_pulse); end
      end
    end
    checks++; if (npulse != 1) begin errors++; $display("FAIL wrap_pulse_count: got %0d want 1", npulse); end
    checks++; if (w1_ovf !== 1'b0) begin errors++; $display("FAIL w1_ovf_early: got %0b want 0", w1_ovf); end
    cnt_in = 4'd8;
    repeat (6) @(negedge clk);
    cnt_in = 4'd0;
    repeat (6) @(negedge clk);
    checks++; if (w1_ovf !== 1'b1) begin errors++; $display("FAIL w1_ovf: got %0b want 1", w1_ovf); end
    checks++; if (ovf !== 1'b0 || out_count !== 16'h0020) begin
      errors++; $display("FAIL second_wrap: got ovf=%0b count=%h want 0/0020", ovf, out_count); end
  endtask

  task automatic test_glitch_skip();
    int bad;
    bad = 0;
    cnt_in = 4'd7;
    repeat (6) @(negedge clk);
    cnt_in = 4'd4;
    @(negedge clk);
    if (out_valid !== 1'b0 || wrap_pulse !== 1'b0) bad++;
    cnt_in = 4'd7;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || wrap_pulse !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL glitch_filtered: got %0d active cycles want 0", bad); end
    cnt_in = 4'd3;
    repeat (6) @(negedge clk);
    cnt_in = 4'd6;
    repeat (6) @(negedge clk);
    checks++; if (out_count !== 16'h0036) begin errors++; $display("FAIL skip_emit: got %h want 0036", out_count); end
    checks++; if (err_skip !== SKIP_EN) begin errors++; $display("FAIL err_skip: got %0b want %0b", err_skip, SKIP_EN); end
  endtask

  task automatic test_reset_midop();
    int bad;
    bad = 0;
    out_ready = 1'b0; cnt_in = 4'd9;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_count !== 16'h0039) begin
      errors++; $display("FAIL pre_reset: got valid=%0b count=%h want 1/0039", out_valid, out_count); end
    rst = 1'b1; smp_en = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_count !== 16'h0 || ovf !== 1'b0 || w1_ovf !== 1'b0 || err_skip !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got valid=%0b count=%h ovf=%0b w1ovf=%0b skip=%0b want all 0",
                         out_valid, out_count, ovf, w1_ovf, err_skip); end
    rst = 1'b0; cnt_in = 4'd10;
    repeat (5) @(negedge clk);
    smp_en = 1'b1; out_ready = 1'b1;
    repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
    cnt_in = 4'd11;
    repeat (5) begin @(negedge clk); if (out_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rebaseline: got %0d valid cycles want 0", bad); end
    cnt_in = 4'd12;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_count !== 16'h000C) begin
      errors++; $display("FAIL post_reset_emit: got valid=%0b count=%h want 1/000C", out_valid, out_count); end
  endtask

  task automatic test_random();
    int hold, base, r, shown;
    base = int'(cnt_in); shown = 0;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) rst = 1'b1;
      smp_en = ($urandom_range(0, 19) != 0);
      if (r < 15) begin
        cnt_in = 4'($urandom_range(0, 15));
        hold = 1;
      end else begin
        base = (base + ((r < 80) ? 1 : $urandom_range(2, 5))) % 16;
        cnt_in = 4'(base);
        hold = $urandom_range(1, 5);
      end
      for (int c = 0; c < hold; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== m_valid || out_count !== 16'(m_count) || wrap_pulse !== m_pulse ||
            ovf !== m_ovf12 || err_skip !== m_skip || w1_ovf !== m_ovf1 || w1_pulse !== m_pulse) begin
          errors++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random_cycle%0d: got v=%0b c=%h p=%0b o=%0b s=%0b o1=%0b want v=%0b c=%h p=%0b o=%0b s=%0b o1=%0b",
                     n, out_valid, out_count, wrap_pulse, ovf, err_skip, w1_ovf,
                     m_valid, 16'(m_count), m_pulse, m_ovf12, m_skip, m_ovf1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_backpressure();
    test_wrap();
    test_glitch_skip();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
